// File: rtl/mem_dbus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_dbus_ctrl_pkg
// Shared MEM-stage definitions: access sizes, the EX/MEM access request
// record, the data-bus responder state encoding, the default bus timeout and
// a lane helper that yields byte enables plus the misalignment flag. The lane
// helper is also meant for the MEM-stage load extender, so it stays free of
// any state.
// ---------------------------------------------------------------------------
package mem_dbus_ctrl_pkg;

    // Access size as encoded by the decode stage.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } MemSize_t;

    // Data-bus responder states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } DbusState_t;

    // Cycles to wait for an acknowledge before declaring a bus error.
    localparam int unsigned DBUS_TIMEOUT_DEFAULT = 32'd255;

    // Memory access presented by the EX/MEM pipeline register.
    typedef struct packed {
        logic        ce;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } MemAccessReq_t;

    // Result of the lane helper.
    typedef struct packed {
        logic       misalign;
        logic [3:0] be;
    } LaneInfo_t;

    // Byte enables and misalignment for a size and the low address bits.
    // The reserved size code yields no lanes and no misalignment.
    function automatic LaneInfo_t lane_info(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        LaneInfo_t info;
        info.misalign = 1'b0;
        info.be       = 4'b0000;
        case (size)
            SZ_BYTE: begin
                info.be = 4'b0001 << addr_lo;
            end
            SZ_HALF: begin
                info.misalign = addr_lo[0];
                info.be       = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                info.misalign = (addr_lo != 2'b00);
                info.be       = 4'b1111;
            end
            default: begin
                info.misalign = 1'b0;
                info.be       = 4'b0000;
            end
        endcase
        return info;
    endfunction

endpackage

// File: rtl/mem_dbus_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_dbus_ctrl_if
// Data-bus connection between the MEM-stage responder and the data-bus
// arbiter.
//   req    master->slave  request, held until ack
//   we     master->slave  write
//   addr   master->slave  word-aligned address
//   be     master->slave  byte enables
//   wdata  master->slave  lane-positioned write data
//   ack    slave->master  one-cycle completion pulse
//   rdata  slave->master  read data, valid with ack
// ---------------------------------------------------------------------------
interface mem_dbus_ctrl_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/mem_dbus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_dbus_ctrl
// MEM-stage data-bus responder. Runs one bus transaction per aligned request
// from EX/MEM, stalls the pipeline until the bus acknowledges, returns the
// read word and flags misaligned accesses and bus timeouts.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   mem_req       access from EX/MEM (ce, we, addr, wdata)
//   mem_size      access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   hold          stage held by a later stage
//   flush         pipeline flush
//   stall_req     MEM-stage stall request (combinational)
//   rdata         registered read word, raw lanes
//   rdata_valid   rdata holds the result of the current read
//   except_adel   misaligned load (combinational)
//   except_ades   misaligned store (combinational)
//   bus_err       transaction timed out
//   dbus          data-bus master port
// ---------------------------------------------------------------------------
module mem_dbus_ctrl
    import mem_dbus_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DBUS_TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  MemAccessReq_t         mem_req,
    input  logic [1:0]            mem_size,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  stall_req,
    output logic [31:0]           rdata,
    output logic                  rdata_valid,
    output logic                  except_adel,
    output logic                  except_ades,
    output logic                  bus_err,
    mem_dbus_ctrl_if.master       dbus
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    DbusState_t       state_r;
    DbusState_t       state_nxt_s;
    LaneInfo_t        lane_s;
    logic             start_s;
    logic             timeout_s;
    logic             capture_s;
    logic             drop_req_s;
    logic             load_rdata_s;
    logic             set_err_s;
    logic             clr_status_s;
    logic             stall_req_s;
    logic             dbus_req_r;
    logic             dbus_we_r;
    logic [31:0]      dbus_addr_r;
    logic [3:0]       dbus_be_r;
    logic [31:0]      dbus_wdata_r;
    logic [31:0]      rdata_r;
    logic             rdata_valid_r;
    logic             bus_err_r;
    logic [CNT_W-1:0] cnt_r;

    assign lane_s      = lane_info(mem_size, mem_req.addr[1:0]);
    assign except_adel = mem_req.ce & ~mem_req.we & lane_s.misalign;
    assign except_ades = mem_req.ce &  mem_req.we & lane_s.misalign;
    assign start_s     = mem_req.ce & ~lane_s.misalign & ~flush;
    assign timeout_s   = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, stall request and datapath strobes.
    always_comb begin
        state_nxt_s  = state_r;
        stall_req_s  = 1'b0;
        capture_s    = 1'b0;
        drop_req_s   = 1'b0;
        load_rdata_s = 1'b0;
        set_err_s    = 1'b0;
        clr_status_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_nxt_s = REQ;
                    capture_s   = 1'b1;
                    stall_req_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                stall_req_s = ~flush;
                if (dbus.ack) begin
                    drop_req_s = 1'b1;
                    // An ack coinciding with a flush belongs to a killed
                    // instruction: discard it rather than report it.
                    if (flush) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s  = DONE;
                        load_rdata_s = ~dbus_we_r;
                    end
                end else if (timeout_s) begin
                    drop_req_s = 1'b1;
                    if (flush) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DONE;
                        set_err_s   = 1'b1;
                    end
                end else if (flush) begin
                    // The bus request cannot be withdrawn; wait it out.
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            DONE: begin
                if (flush || !hold) begin
                    state_nxt_s  = IDLE;
                    clr_status_s = 1'b1;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            DRAIN: begin
                // A request arriving after the flush waits for the drain.
                stall_req_s = mem_req.ce;
                if (dbus.ack || timeout_s) begin
                    state_nxt_s = IDLE;
                    drop_req_s  = 1'b1;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s  = IDLE;
                drop_req_s   = 1'b1;
                clr_status_s = 1'b1;
            end
        endcase
    end

    // Bus request fields, timeout counter, read data and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbus_req_r    <= 1'b0;
            dbus_we_r     <= 1'b0;
            dbus_addr_r   <= 32'h0000_0000;
            dbus_be_r     <= 4'b0000;
            dbus_wdata_r  <= 32'h0000_0000;
            rdata_r       <= 32'h0000_0000;
            rdata_valid_r <= 1'b0;
            bus_err_r     <= 1'b0;
            cnt_r         <= {CNT_W{1'b0}};
        end else begin
            if (capture_s) begin
                dbus_req_r   <= 1'b1;
                dbus_we_r    <= mem_req.we;
                dbus_addr_r  <= {mem_req.addr[31:2], 2'b00};
                dbus_be_r    <= lane_s.be;
                dbus_wdata_r <= mem_req.wdata;
                cnt_r        <= {CNT_W{1'b0}};
            end else begin
                if (drop_req_s) begin
                    dbus_req_r <= 1'b0;
                end
                if (((state_r == REQ) || (state_r == DRAIN)) && (cnt_r != CNT_MAX)) begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
            if (load_rdata_s) begin
                rdata_r       <= dbus.rdata;
                rdata_valid_r <= 1'b1;
            end else if (clr_status_s) begin
                rdata_valid_r <= 1'b0;
            end
            if (set_err_s) begin
                bus_err_r <= 1'b1;
            end else if (clr_status_s) begin
                bus_err_r <= 1'b0;
            end
        end
    end

    assign stall_req   = stall_req_s;
    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;
    assign bus_err     = bus_err_r;
    assign dbus.req    = dbus_req_r;
    assign dbus.we     = dbus_we_r;
    assign dbus.addr   = dbus_addr_r;
    assign dbus.be     = dbus_be_r;
    assign dbus.wdata  = dbus_wdata_r;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_dbus_ctrl
// Directed bench for mem_dbus_ctrl. Two instances share the MEM-stage inputs:
// dut (default timeout) carries the functional scenarios, dut_t
// (TIMEOUT_CYCLES=4, never acknowledged) carries the timeout scenario.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. "Cycle n" is counted from the cycle a request is first shown.
// ---------------------------------------------------------------------------
module tb_mem_dbus_ctrl;
    import mem_dbus_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n;
    MemAccessReq_t mem_req;
    logic [1:0]    mem_size;
    logic          hold;
    logic          flush;

    logic          stall_req, rdata_valid, except_adel, except_ades, bus_err;
    logic [31:0]   rdata;
    logic          stall_req_t, rdata_valid_t, except_adel_t, except_ades_t, bus_err_t;
    logic [31:0]   rdata_t;

    int tests_run    = 0;
    int tests_failed = 0;

    mem_dbus_ctrl_if dbus_if ();
    mem_dbus_ctrl_if dbus_t_if ();

    always #5 clk = ~clk;

    mem_dbus_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_size(mem_size),
        .hold(hold), .flush(flush), .stall_req(stall_req), .rdata(rdata),
        .rdata_valid(rdata_valid), .except_adel(except_adel),
        .except_ades(except_ades), .bus_err(bus_err), .dbus(dbus_if)
    );

    mem_dbus_ctrl #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_size(mem_size),
        .hold(hold), .flush(flush), .stall_req(stall_req_t), .rdata(rdata_t),
        .rdata_valid(rdata_valid_t), .except_adel(except_adel_t),
        .except_ades(except_ades_t), .bus_err(bus_err_t), .dbus(dbus_t_if)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic ce, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size);
        mem_req.ce    = ce;
        mem_req.we    = we;
        mem_req.addr  = addr;
        mem_req.wdata = wdata;
        mem_size      = size;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            set_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD);
        dbus_if.ack     = 1'b0;
        dbus_if.rdata   = 32'h0;
        dbus_t_if.ack   = 1'b0;
        dbus_t_if.rdata = 32'h0;
        #2;
        tests_run++; if (dbus_if.req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b exp 0", dbus_if.req); end
        tests_run++; if (dbus_if.addr !== 32'h0 || dbus_if.be !== 4'h0 || dbus_if.we !== 1'b0 || dbus_if.wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_bus: got addr %h be %b we %b wdata %h exp zeros", dbus_if.addr, dbus_if.be, dbus_if.we, dbus_if.wdata); end
        tests_run++; if (rdata !== 32'h0 || rdata_valid !== 1'b0 || bus_err !== 1'b0 || stall_req !== 1'b0) begin tests_failed++; $display("FAIL reset_out: got rdata %h valid %b err %b stall %b exp zeros", rdata, rdata_valid, bus_err, stall_req); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_word_read();
        next_cycle();
        set_req(1'b1, 1'b0, 32'h8000_0010, 32'h0, SZ_WORD);
        @(negedge clk);
        tests_run++; if (stall_req !== 1'b1) begin tests_failed++; $display("FAIL rd_stall c0: got %b exp 1", stall_req); end
        tests_run++; if (dbus_if.req !== 1'b0) begin tests_failed++; $display("FAIL rd_req c0: got %b exp 0", dbus_if.req); end
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            if (c == 3) begin dbus_if.ack = 1'b1; dbus_if.rdata = 32'hDEAD_BEEF; end
            @(negedge clk);
            tests_run++; if (stall_req !== 1'b1 || dbus_if.req !== 1'b1) begin tests_failed++; $display("FAIL rd_busy c%0d: got stall %b req %b exp 1 1", c, stall_req, dbus_if.req); end
            if (c == 1) begin
                tests_run++; if (dbus_if.addr !== 32'h8000_0010 || dbus_if.be !== 4'b1111 || dbus_if.we !== 1'b0) begin tests_failed++; $display("FAIL rd_fields: got addr %h be %b we %b exp 80000010 1111 0", dbus_if.addr, dbus_if.be, dbus_if.we); end
            end
        end
        next_cycle();
        dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0;
        @(negedge clk);
        tests_run++; if (rdata !== 32'hDEAD_BEEF || rdata_valid !== 1'b1) begin tests_failed++; $display("FAIL rd_data c4: got %h valid %b exp deadbeef 1", rdata, rdata_valid); end
        tests_run++; if (stall_req !== 1'b0 || dbus_if.req !== 1'b0) begin tests_failed++; $display("FAIL rd_done c4: got stall %b req %b exp 0 0", stall_req, dbus_if.req); end
        next_cycle();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD);
        @(negedge clk);
        tests_run++; if (rdata_valid !== 1'b0) begin tests_failed++; $display("FAIL rd_valid_clr c5: got %b exp 0", rdata_valid); end
    endtask

    task automatic test_store_lanes();
        next_cycle();
        set_req(1'b1, 1'b1, 32'h8000_0003, 32'hAB00_0000, SZ_BYTE);
        next_cycle();
        dbus_if.ack = 1'b1;
        @(negedge clk);
        tests_run++; if (dbus_if.req !== 1'b1 || dbus_if.be !== 4'b1000 || dbus_if.we !== 1'b1) begin tests_failed++; $display("FAIL sb_fields: got req %b be %b we %b exp 1 1000 1", dbus_if.req, dbus_if.be, dbus_if.we); end
        tests_run++; if (dbus_if.addr !== 32'h8000_0000 || dbus_if.wdata !== 32'hAB00_0000) begin tests_failed++; $display("FAIL sb_addr: got addr %h wdata %h exp 80000000 ab000000", dbus_if.addr, dbus_if.wdata); end
        next_cycle();
        dbus_if.ack = 1'b0;
        @(negedge clk);
        tests_run++; if (stall_req !== 1'b0 || dbus_if.req !== 1'b0) begin tests_failed++; $display("FAIL sb_done c2: got stall %b req %b exp 0 0", stall_req, dbus_if.req); end
        // Back-to-back: next instruction is a halfword store to the upper lanes.
        next_cycle();
        set_req(1'b1, 1'b1, 32'h0000_2002, 32'h5A5A_0000, SZ_HALF);
        @(negedge clk);
        tests_run++; if (stall_req !== 1'b1) begin tests_failed++; $display("FAIL sh_stall: got %b exp 1", stall_req); end
        next_cycle();
        dbus_if.ack = 1'b1;
        @(negedge clk);
        tests_run++; if (dbus_if.be !== 4'b1100 || dbus_if.addr !== 32'h0000_2000 || dbus_if.wdata !== 32'h5A5A_0000) begin tests_failed++; $display("FAIL sh_fields: got be %b addr %h wdata %h exp 1100 00002000 5a5a0000", dbus_if.be, dbus_if.addr, dbus_if.wdata); end
        next_cycle();
        dbus_if.ack = 1'b0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD);
        idle_cycles(2);
    endtask

    task automatic test_misalign();
        next_cycle();
        set_req(1'b1, 1'b0, 32'h0000_1001, 32'h0, SZ_HALF);
        @(negedge clk);
        tests_run++; if (except_adel !== 1'b1 || except_ades !== 1'b0 || stall_req !== 1'b0) begin tests_failed++; $display("FAIL adel: got adel %b ades %b stall %b exp 1 0 0", except_adel, except_ades, stall_req); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (dbus_if.req !== 1'b0) begin tests_failed++; $display("FAIL adel_noreq: got %b exp 0", dbus_if.req); end
        next_cycle();
        set_req(1'b1, 1'b1, 32'h0000_1002, 32'h1234_5678, SZ_WORD);
        @(negedge clk);
        tests_run++; if (except_ades !== 1'b1 || except_adel !== 1'b0 || stall_req !== 1'b0) begin tests_failed++; $display("FAIL ades: got ades %b adel %b stall %b exp 1 0 0", except_ades, except_adel, stall_req); end
        next_cycle();
        @(negedge clk);
        tests_run++; if (dbus_if.req !== 1'b0) begin tests_failed++; $display("FAIL ades_noreq: got %b exp 0", dbus_if.req); end
        idle_cycles(1);
    endtask

    task automatic test_flush_drain();
        next_cycle();
        set_req(1'b1, 1'b0, 32'h0000_0100, 32'h0, SZ_WORD);
        next_cycle();
        @(negedge clk);
        tests_run++; if (dbus_if.req !== 1'b1) begin tests_failed++; $display("FAIL fl_req c1: got %b exp 1", dbus_if.req); end
        next_cycle();
        flush = 1'b1;
        @(negedge clk);
        tests_run++; if (stall_req !== 1'b0) begin tests_failed++; $display("FAIL fl_stall c2: got %b exp 0", stall_req); end
        for (int c = 3; c <= 5; c++) begin
            next_cycle();
            flush = 1'b0;
            if (c == 3) set_req(1'b1, 1'b0, 32'h0000_0200, 32'h0, SZ_WORD);
            if (c == 5) begin dbus_if.ack = 1'b1; dbus_if.rdata = 32'h1111_1111; end
            @(negedge clk);
            tests_run++; if (dbus_if.req !== 1'b1 || stall_req !== 1'b1 || rdata_valid !== 1'b0) begin tests_failed++; $display("FAIL fl_drain c%0d: got req %b stall %b valid %b exp 1 1 0", c, dbus_if.req, stall_req, rdata_valid); end
            tests_run++; if (dbus_if.addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL fl_addr_hold c%0d: got %h exp 00000100", c, dbus_if.addr); end
        end
        next_cycle();
        dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0;
        @(negedge clk);
        tests_run++; if (dbus_if.req !== 1'b0 || stall_req !== 1'b1 || rdata_valid !== 1'b0) begin tests_failed++; $display("FAIL fl_c6: got req %b stall %b valid %b exp 0 1 0", dbus_if.req, stall_req, rdata_valid); end
        next_cycle();
        dbus_if.ack = 1'b1; dbus_if.rdata = 32'h2222_2222;
        @(negedge clk);
        tests_run++; if (dbus_if.req !== 1'b1 || dbus_if.addr !== 32'h0000_0200 || rdata_valid !== 1'b0) begin tests_failed++; $display("FAIL fl_c7: got req %b addr %h valid %b exp 1 00000200 0", dbus_if.req, dbus_if.addr, rdata_valid); end
        next_cycle();
        dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0;
        @(negedge clk);
        tests_run++; if (rdata !== 32'h2222_2222 || rdata_valid !== 1'b1) begin tests_failed++; $display("FAIL fl_c8: got %h valid %b exp 22222222 1", rdata, rdata_valid); end
        idle_cycles(8);
    endtask

    task automatic test_timeout();
        next_cycle();
        set_req(1'b1, 1'b0, 32'h0000_0300, 32'h0, SZ_WORD);
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            @(negedge clk);
            tests_run++; if (dbus_t_if.req !== 1'b1 || stall_req_t !== 1'b1) begin tests_failed++; $display("FAIL to_wait c%0d: got req %b stall %b exp 1 1", c, dbus_t_if.req, stall_req_t); end
        end
        next_cycle();
        @(negedge clk);
        tests_run++; if (dbus_t_if.req !== 1'b0 || bus_err_t !== 1'b1 || stall_req_t !== 1'b0 || rdata_valid_t !== 1'b0) begin tests_failed++; $display("FAIL to_err c5: got req %b err %b stall %b valid %b exp 0 1 0 0", dbus_t_if.req, bus_err_t, stall_req_t, rdata_valid_t); end
        next_cycle();
        set_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD);
        dbus_if.ack = 1'b1;
        @(negedge clk);
        tests_run++; if (bus_err_t !== 1'b0) begin tests_failed++; $display("FAIL to_err_clr c6: got %b exp 0", bus_err_t); end
        next_cycle();
        dbus_if.ack = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_hold();
        int req_cycles = 0;
        next_cycle();
        set_req(1'b1, 1'b0, 32'h0000_0400, 32'h0, SZ_WORD);
        @(negedge clk);
        if (dbus_if.req === 1'b1) req_cycles++;
        next_cycle();
        dbus_if.ack = 1'b1; dbus_if.rdata = 32'hCAFE_F00D;
        @(negedge clk);
        if (dbus_if.req === 1'b1) req_cycles++;
        for (int c = 2; c <= 5; c++) begin
            next_cycle();
            dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0;
            hold = (c <= 4);
            @(negedge clk);
            if (dbus_if.req === 1'b1) req_cycles++;
            tests_run++; if (rdata_valid !== 1'b1 || rdata !== 32'hCAFE_F00D || stall_req !== 1'b0) begin tests_failed++; $display("FAIL hold_c%0d: got valid %b rdata %h stall %b exp 1 cafef00d 0", c, rdata_valid, rdata, stall_req); end
        end
        for (int c = 6; c <= 7; c++) begin
            next_cycle();
            set_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD);
            @(negedge clk);
            if (dbus_if.req === 1'b1) req_cycles++;
            tests_run++; if (rdata_valid !== 1'b0) begin tests_failed++; $display("FAIL hold_release c%0d: got %b exp 0", c, rdata_valid); end
        end
        tests_run++; if (req_cycles !== 1) begin tests_failed++; $display("FAIL hold_single_txn: got %0d request cycles exp 1", req_cycles); end
    endtask

    task automatic test_async_reset();
        next_cycle();
        set_req(1'b1, 1'b1, 32'h0000_0504, 32'h7777_8888, SZ_WORD);
        next_cycle();
        @(negedge clk);
        tests_run++; if (dbus_if.req !== 1'b1 || dbus_if.addr !== 32'h0000_0504) begin tests_failed++; $display("FAIL ar_pre: got req %b addr %h exp 1 00000504", dbus_if.req, dbus_if.addr); end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (dbus_if.req !== 1'b0 || dbus_if.addr !== 32'h0 || dbus_if.we !== 1'b0 || dbus_if.be !== 4'h0 || dbus_if.wdata !== 32'h0) begin tests_failed++; $display("FAIL ar_bus: got req %b addr %h we %b be %b wdata %h exp zeros", dbus_if.req, dbus_if.addr, dbus_if.we, dbus_if.be, dbus_if.wdata); end
        tests_run++; if (rdata !== 32'h0 || rdata_valid !== 1'b0 || bus_err !== 1'b0) begin tests_failed++; $display("FAIL ar_out: got rdata %h valid %b err %b exp zeros", rdata, rdata_valid, bus_err); end
        set_req(1'b0, 1'b0, 32'h0, 32'h0, SZ_WORD);
        #1;
        tests_run++; if (stall_req !== 1'b0) begin tests_failed++; $display("FAIL ar_stall: got %b exp 0", stall_req); end
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        dbus_if.ack = 1'b1; dbus_if.rdata = 32'h9999_9999;
        next_cycle();
        dbus_if.ack = 1'b0; dbus_if.rdata = 32'h0;
        @(negedge clk);
        tests_run++; if (rdata_valid !== 1'b0 || dbus_if.req !== 1'b0 || rdata !== 32'h0) begin tests_failed++; $display("FAIL ar_stale_ack: got valid %b req %b rdata %h exp 0 0 0", rdata_valid, dbus_if.req, rdata); end
    endtask

    initial begin
        test_reset();
        test_word_read();
        test_store_lanes();
        test_misalign();
        test_flush_drain();
        test_timeout();
        test_hold();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
